vga_scanout: RTL

Display-side consumer of the double-buffered frame store. Walks standard 640x480@60 VGA timing on the pixel clock and reads the flattened `packed_buffer` at pixel-replicated coordinates. Drives sync, data-enable and pixel colour to the DAC/pins. Owns the front/back buffer selection and swaps it only at the start of vertical blanking, in response to a swap-request handshake from the rendering side.

---
 rtl/vga_scanout_pkg.sv | 30 +++
 rtl/vga_timing.sv | 58 +++++
 rtl/vga_scanout.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_pkg.sv
// Frame-store geometry and VGA 640x480@60 timing shared by the frame store and scanout.
// Also holds the swap FSM state type and a counter-width helper.
package vga_scanout_pkg;

    localparam int WIDTH      = 40;
    localparam int HEIGHT     = 30;
    localparam int PIXEL_SIZE = 3;
    localparam int FB_BITS    = WIDTH * HEIGHT * PIXEL_SIZE;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with combinational region decode and strobes.
// Decode is valid in the same cycle as the counters; no backpressure.
module vga_timing #(
    parameter  int H_ACTIVE = vga_scanout_pkg::H_ACTIVE,
    parameter  int H_FP     = vga_scanout_pkg::H_FP,
    parameter  int H_SYNC   = vga_scanout_pkg::H_SYNC,
    parameter  int H_BP     = vga_scanout_pkg::H_BP,
    parameter  int V_ACTIVE = vga_scanout_pkg::V_ACTIVE,
    parameter  int V_FP     = vga_scanout_pkg::V_FP,
    parameter  int V_SYNC   = vga_scanout_pkg::V_SYNC,
    parameter  int V_BP     = vga_scanout_pkg::V_BP,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic clk,
    input  logic resetn,
    output logic o_active,
    output logic o_hsync_n,
    output logic o_vsync_n,
    output logic o_line_end,
    output logic o_frame_end,
    output logic o_vblank_start,
    output logic o_frame_start
);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign o_active       = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign o_hsync_n      = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                              (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vsync_n      = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                              (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_line_end     = w_h_last;
    assign o_frame_end    = w_h_last && w_v_last;
    assign o_vblank_start = (r_h_cnt == '0) && (r_v_cnt == VW'(V_ACTIVE));
    assign o_frame_start  = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// Scans the front buffer out as VGA with pixel replication and owns the front/back swap.
// All outputs registered once (1 clk after counter state); display side takes no backpressure.
module vga_scanout #(
    parameter  int WIDTH      = vga_scanout_pkg::WIDTH,
    parameter  int HEIGHT     = vga_scanout_pkg::HEIGHT,
    parameter  int PIXEL_SIZE = vga_scanout_pkg::PIXEL_SIZE,
    parameter  int H_ACTIVE   = vga_scanout_pkg::H_ACTIVE,
    parameter  int H_FP       = vga_scanout_pkg::H_FP,
    parameter  int H_SYNC     = vga_scanout_pkg::H_SYNC,
    parameter  int H_BP       = vga_scanout_pkg::H_BP,
    parameter  int V_ACTIVE   = vga_scanout_pkg::V_ACTIVE,
    parameter  int V_FP       = vga_scanout_pkg::V_FP,
    parameter  int V_SYNC     = vga_scanout_pkg::V_SYNC,
    parameter  int V_BP       = vga_scanout_pkg::V_BP,
    localparam int SCALE_X    = H_ACTIVE / WIDTH,
    localparam int SCALE_Y    = V_ACTIVE / HEIGHT,
    localparam int FB_BITS    = WIDTH * HEIGHT * PIXEL_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [FB_BITS-1:0]    packed_buffer,
    input  logic                  swap_req,
    output logic                  front_sel,
    output logic                  swap_ack,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [PIXEL_SIZE-1:0] rgb,
    output logic                  frame_start
);
    import vga_scanout_pkg::*;

    if (((H_ACTIVE % WIDTH) != 0) || ((V_ACTIVE % HEIGHT) != 0)) begin : g_scale_check
        $error("vga_scanout: active area is not an exact multiple of the frame size");
    end

    localparam int SXW      = cnt_width(SCALE_X);
    localparam int SYW      = cnt_width(SCALE_Y);
    localparam int OFFW     = cnt_width(FB_BITS);
    localparam int COL_LAST = (WIDTH - 1) * PIXEL_SIZE;
    localparam int ROW_STEP = WIDTH * PIXEL_SIZE;
    localparam int ROW_LAST = (HEIGHT - 1) * WIDTH * PIXEL_SIZE;

    logic w_active;
    logic w_hsync_n;
    logic w_vsync_n;
    logic w_line_end;
    logic w_frame_end;
    logic w_vblank_start;
    logic w_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk            (clk),
        .resetn         (resetn),
        .o_active       (w_active),
        .o_hsync_n      (w_hsync_n),
        .o_vsync_n      (w_vsync_n),
        .o_line_end     (w_line_end),
        .o_frame_end    (w_frame_end),
        .o_vblank_start (w_vblank_start),
        .o_frame_start  (w_frame_start)
    );

    // Column and row are kept as bit offsets into packed_buffer (col*PIXEL_SIZE and
    // row*WIDTH*PIXEL_SIZE) so the fetch is a pure add; both saturate past the active area.
    logic [SXW-1:0]  r_sx;
    logic [SYW-1:0]  r_sy;
    logic [OFFW-1:0] r_col_off;
    logic [OFFW-1:0] r_row_off;
    logic [OFFW-1:0] w_pix_off;
    logic [PIXEL_SIZE-1:0] w_pix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sx      <= '0;
            r_col_off <= '0;
            r_sy      <= '0;
            r_row_off <= '0;
        end else begin
            if (w_line_end) begin
                r_sx      <= '0;
                r_col_off <= '0;
            end else if (r_sx == SXW'(SCALE_X - 1)) begin
                r_sx <= '0;
                if (r_col_off != OFFW'(COL_LAST))
                    r_col_off <= r_col_off + OFFW'(PIXEL_SIZE);
            end else begin
                r_sx <= r_sx + SXW'(1);
            end

            if (w_frame_end) begin
                r_sy      <= '0;
                r_row_off <= '0;
            end else if (w_line_end) begin
                if (r_sy == SYW'(SCALE_Y - 1)) begin
                    r_sy <= '0;
                    if (r_row_off != OFFW'(ROW_LAST))
                        r_row_off <= r_row_off + OFFW'(ROW_STEP);
                end else begin
                    r_sy <= r_sy + SYW'(1);
                end
            end
        end
    end

    assign w_pix_off = r_row_off + r_col_off;
    assign w_pix     = packed_buffer[w_pix_off +: PIXEL_SIZE];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= w_hsync_n;
            vsync       <= w_vsync_n;
            de          <= w_active;
            rgb         <= w_active ? w_pix : '0;
            frame_start <= w_frame_start;
        end
    end

    // Request is resynchronised before edge detection, so an edge seen on the
    // vblank-start cycle only arms the swap for the following frame.
    swap_state_t r_state;
    logic        r_req_q;
    logic        r_req_qq;
    logic        w_req_edge;

    assign w_req_edge = r_req_q && !r_req_qq;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req_q   <= 1'b0;
            r_req_qq  <= 1'b0;
            r_state   <= SWAP_IDLE;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            r_req_q  <= swap_req;
            r_req_qq <= r_req_q;
            swap_ack <= 1'b0;
            case (r_state)
                SWAP_IDLE: begin
                    if (w_req_edge)
                        r_state <= SWAP_PENDING;
                end
                SWAP_PENDING: begin
                    if (w_vblank_start) begin
                        front_sel <= !front_sel;
                        swap_ack  <= 1'b1;
                        r_state   <= SWAP_IDLE;
                    end
                end
                default: r_state <= SWAP_IDLE;
            endcase
        end
    end

endmodule
